tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 137 +++++++++++++
 tb/tb_tx_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// tx_scheduler
//   Round-robin scheduler that feeds bytes from four requesters into a single
//   UART transmitter. A winner is chosen in IDLE, its byte is latched and
//   launched, and the requester is acknowledged once the transmitter shows
//   it has taken the byte (tbr falls). If tbr never falls, a sticky error is
//   raised and the same requester gets another chance.
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [3:0]  per-requester transmit request
//   req_data  in   [31:0] byte for requester i on bits [8i+7:8i]
//   tbr       in   transmitter ready (1 = idle, 0 = shifting)
//   err_clr   in   synchronous clear of err
//   ack       out  [3:0]  one-cycle accept pulse, one-hot
//   tx_start  out  one-cycle launch strobe
//   tx_data   out  [7:0]  byte being transmitted, held until IDLE
//   busy      out  high whenever the FSM is not in IDLE
//   grant_id  out  [1:0]  requester currently / most recently served
//   err       out  sticky timeout flag

module tx_scheduler #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic        tbr,
    input  logic        err_clr,
    output logic [3:0]  ack,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] last_grant;
    logic [7:0] timeout_cnt;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;

    // Round-robin search starting just after the last acknowledged requester.
    // The 2-bit add wraps 3 -> 0 naturally.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        idx    = last_grant;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            ack         <= 4'b0000;
            tx_data     <= 8'h00;
            grant_id    <= 2'd0;
            last_grant  <= 2'd3;
            err         <= 1'b0;
            busy        <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            tx_start <= 1'b0;
            ack      <= 4'b0000;

            // The timeout branch below assigns err later, so a simultaneous
            // timeout wins over the clear.
            if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tbr && found) begin
                        tx_data  <= req_data[{winner, 3'b000} +: 8];
                        grant_id <= winner;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    timeout_cnt <= 8'd0;
                    state       <= WAIT_LOW;
                end

                WAIT_LOW: begin
                    if (!tbr) begin
                        ack        <= 4'b0001 << grant_id;
                        last_grant <= grant_id;
                        state      <= WAIT_HIGH;
                    end else if (timeout_cnt >= TIMEOUT_LAST) begin
                        // last_grant untouched so the same requester is retried
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timeout_cnt != 8'hFF) begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end

                WAIT_HIGH: begin
                    if (tbr) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler
//   Self-checking bench for tx_scheduler. Expected grants/bytes are queued
//   when requests are driven and popped when the launch is observed. Inputs
//   are driven and outputs sampled on the falling clock edge.

module tb_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tbr;
    logic        err_clr;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    tx_scheduler #(.TIMEOUT(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .tbr      (tbr),
        .err_clr  (err_clr),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n    = 1'b0;
        tbr      = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for a launch, then plays a transmitter: tbr falls fall_delay
    // cycles after the launch cycle and rises high_len cycles later.
    task automatic run_transfer(input int fall_delay, input int high_len, input bit drop,
                                output bit started, output logic [1:0] id,
                                output logic [7:0] data, output logic [3:0] ack_seen,
                                output int ack_pulses, output int ack_lat, output bit viol);
        started    = 1'b0;
        id         = 2'd0;
        data       = 8'h00;
        ack_seen   = 4'b0000;
        ack_pulses = 0;
        ack_lat    = -1;
        viol       = 1'b0;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge clk);
            if (tx_start) started = 1'b1;
        end
        if (!started) return;
        id   = grant_id;
        data = tx_data;
        if (ack !== 4'b0000) viol = 1'b1;
        if (drop) begin
            req      = 4'b0000;
            req_data = ~req_data;
        end
        for (int c = 1; c <= fall_delay + high_len; c++) begin
            @(negedge clk);
            if (tx_start) viol = 1'b1;
            if (tx_data !== data) viol = 1'b1;
            if (ack !== 4'b0000) begin
                ack_pulses++;
                ack_seen = ack_seen | ack;
                if ($countones(ack) != 1) viol = 1'b1;
                if (ack_lat < 0) ack_lat = c - fall_delay;
            end
            if (c == fall_delay) tbr = 1'b0;
            if (c == fall_delay + high_len) tbr = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tbr      = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        err_clr  = 1'b0;
        #3;
        n_checks++; if (tx_start !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_checks++; if (ack !== 4'b0000) begin n_fails++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
        n_checks++; if (tx_data !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_checks++; if (grant_id !== 2'd0) begin n_fails++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (err !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_idle_hold();
        bit launched = 1'b0;
        do_reset();
        tbr = 1'b0;
        req = 4'b0001;
        repeat (6) begin
            @(negedge clk);
            if (tx_start || busy) launched = 1'b1;
        end
        n_checks++; if (launched !== 1'b0) begin n_fails++; $display("[TB] FAIL idle_hold: got launch=%b expected 0", launched); end
        req = 4'b0000;
        tbr = 1'b1;
    endtask

    task automatic test_single();
        bit started, viol; logic [1:0] id; logic [7:0] data; logic [3:0] ack_seen;
        int pulses, lat; exp_t e;
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        exp_q.push_back('{id: 2'd0, data: 8'hA5});
        run_transfer(2, 100, 1'b1, started, id, data, ack_seen, pulses, lat, viol);
        n_checks++; if (!started) begin n_fails++; $display("[TB] FAIL single_start: got no launch expected launch"); end
        e = exp_q.pop_front();
        n_checks++; if (data !== e.data) begin n_fails++; $display("[TB] FAIL single_data: got %h expected %h", data, e.data); end
        n_checks++; if (id !== e.id) begin n_fails++; $display("[TB] FAIL single_id: got %0d expected %0d", id, e.id); end
        n_checks++; if (ack_seen !== 4'b0001 || pulses != 1) begin n_fails++; $display("[TB] FAIL single_ack: got %b x%0d expected 0001 x1", ack_seen, pulses); end
        n_checks++; if (lat != 1) begin n_fails++; $display("[TB] FAIL single_ack_latency: got %0d expected 1", lat); end
        n_checks++; if (viol) begin n_fails++; $display("[TB] FAIL single_protocol: got violation expected none"); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL single_busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        bit started, viol; logic [1:0] id; logic [7:0] data; logic [3:0] ack_seen;
        int pulses, lat; exp_t e; int per_bit[4];
        logic [1:0] order[5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) per_bit[k] = 0;
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{id: order[k], data: 8'h11 * (8'(order[k]) + 8'd1)});
        for (int k = 0; k < 5; k++) begin
            run_transfer(2, 3, 1'b0, started, id, data, ack_seen, pulses, lat, viol);
            e = exp_q.pop_front();
            n_checks++; if (!started || id !== e.id || data !== e.data) begin n_fails++; $display("[TB] FAIL rr_grant_%0d: got id=%0d data=%h expected id=%0d data=%h", k, id, data, e.id, e.data); end
            n_checks++; if (ack_seen !== (4'b0001 << e.id) || pulses != 1 || viol) begin n_fails++; $display("[TB] FAIL rr_ack_%0d: got %b x%0d expected %b x1", k, ack_seen, pulses, 4'b0001 << e.id); end
            if (k < 4) per_bit[e.id] += pulses;
        end
        req = 4'b0000;
        n_checks++; if (per_bit[0] != 1 || per_bit[1] != 1 || per_bit[2] != 1 || per_bit[3] != 1) begin n_fails++; $display("[TB] FAIL rr_per_round: got %0d%0d%0d%0d expected 1111", per_bit[0], per_bit[1], per_bit[2], per_bit[3]); end
    endtask

    task automatic test_wrap_skip();
        bit started, viol; logic [1:0] id; logic [7:0] data; logic [3:0] ack_seen;
        int pulses, lat; exp_t e;
        do_reset();
        req      = 4'b0100;
        req_data = 32'h005A_0000;
        exp_q.push_back('{id: 2'd2, data: 8'h5A});
        run_transfer(2, 3, 1'b1, started, id, data, ack_seen, pulses, lat, viol);
        e = exp_q.pop_front();
        n_checks++; if (!started || id !== e.id || data !== e.data) begin n_fails++; $display("[TB] FAIL wrap_setup: got id=%0d data=%h expected id=%0d data=%h", id, data, e.id, e.data); end
        req_data = 32'h0000_C2C1;
        req      = 4'b0011;
        exp_q.push_back('{id: 2'd0, data: 8'hC1});
        exp_q.push_back('{id: 2'd1, data: 8'hC2});
        for (int k = 0; k < 2; k++) begin
            run_transfer(2, 3, 1'b0, started, id, data, ack_seen, pulses, lat, viol);
            e = exp_q.pop_front();
            n_checks++; if (!started || id !== e.id || data !== e.data || ack_seen !== (4'b0001 << e.id)) begin n_fails++; $display("[TB] FAIL wrap_order_%0d: got id=%0d data=%h ack=%b expected id=%0d data=%h", k, id, data, ack_seen, e.id, e.data); end
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        bit started = 1'b0;
        bit ack_bad = 1'b0;
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000_0077;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge clk);
            if (tx_start) started = 1'b1;
        end
        n_checks++; if (!started) begin n_fails++; $display("[TB] FAIL timeout_start: got no launch expected launch"); end
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (n <= 33 && ack !== 4'b0000) ack_bad = 1'b1;
            if (n == 32) begin
                n_checks++; if (err !== 1'b0) begin n_fails++; $display("[TB] FAIL timeout_early: got err=%b expected 0", err); end
                err_clr = 1'b1;
            end
            if (n == 33) begin
                n_checks++; if (err !== 1'b1) begin n_fails++; $display("[TB] FAIL timeout_set_wins: got err=%b expected 1", err); end
                n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL timeout_idle: got busy=%b expected 0", busy); end
                err_clr = 1'b0;
            end
            if (n == 34) begin
                n_checks++; if (tx_start !== 1'b1 || grant_id !== 2'd0) begin n_fails++; $display("[TB] FAIL timeout_retry: got start=%b id=%0d expected start=1 id=0", tx_start, grant_id); end
                n_checks++; if (err !== 1'b1) begin n_fails++; $display("[TB] FAIL timeout_sticky: got err=%b expected 1", err); end
                err_clr = 1'b1;
                req     = 4'b0000;
            end
            if (n == 35) begin
                n_checks++; if (err !== 1'b0) begin n_fails++; $display("[TB] FAIL timeout_clear: got err=%b expected 0", err); end
                err_clr = 1'b0;
            end
        end
        n_checks++; if (ack_bad) begin n_fails++; $display("[TB] FAIL timeout_no_ack: got ack pulse expected none"); end
    endtask

    task automatic test_data_stability();
        bit started, viol; logic [1:0] id; logic [7:0] data; logic [3:0] ack_seen;
        int pulses, lat; exp_t e;
        do_reset();
        req      = 4'b0010;
        req_data = 32'h0000_3C00;
        exp_q.push_back('{id: 2'd1, data: 8'h3C});
        run_transfer(2, 4, 1'b1, started, id, data, ack_seen, pulses, lat, viol);
        e = exp_q.pop_front();
        n_checks++; if (!started || data !== e.data || viol) begin n_fails++; $display("[TB] FAIL stable_data: got %h viol=%b expected %h", data, viol, e.data); end
        n_checks++; if (ack_seen !== 4'b0010 || pulses != 1) begin n_fails++; $display("[TB] FAIL stable_ack: got %b x%0d expected 0010 x1", ack_seen, pulses); end
    endtask

    task automatic test_reset_mid_op();
        bit started, viol; logic [1:0] id; logic [7:0] data; logic [3:0] ack_seen;
        int pulses, lat; exp_t e;
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000_0011;
        started  = 1'b0;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge clk);
            if (tx_start) started = 1'b1;
        end
        req = 4'b0000;
        @(negedge clk);
        tbr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || !started) begin n_fails++; $display("[TB] FAIL midop_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_start !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || err !== 1'b0) begin n_fails++; $display("[TB] FAIL midop_reset_ctrl: got start=%b ack=%b busy=%b err=%b expected 0 0000 0 0", tx_start, ack, busy, err); end
        n_checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin n_fails++; $display("[TB] FAIL midop_reset_data: got data=%h id=%0d expected 00 0", tx_data, grant_id); end
        @(negedge clk);
        tbr      = 1'b1;
        req      = 4'b0100;
        req_data = 32'h0077_0000;
        exp_q.push_back('{id: 2'd2, data: 8'h77});
        @(negedge clk);
        rst_n = 1'b1;
        run_transfer(2, 3, 1'b1, started, id, data, ack_seen, pulses, lat, viol);
        e = exp_q.pop_front();
        n_checks++; if (!started || id !== e.id || data !== e.data || ack_seen !== 4'b0100 || pulses != 1) begin n_fails++; $display("[TB] FAIL midop_restart: got id=%0d data=%h ack=%b expected id=%0d data=%h ack=0100", id, data, ack_seen, e.id, e.data); end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_data_stability();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
